// File: rtl/i2c_target_8bit.sv
// i2c_target_8bit: oversampled I2C/SCCB target with an 8-bit register pointer.
// Answers START / slave-addr / reg-addr / data / STOP sequences on an
// open-drain bus and exposes a simple register-file port.
//
// Build option: define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample
// stability filter on the synchronized SCL/SDA (adds 2 cycles of latency).
//
// Ports:
//   i_clk, i_rst    system clock, synchronous active-high reset
//   i_scl, i_sda    resolved bus levels (asynchronous to i_clk)
//   o_sda_oe        1 = pull SDA low, 0 = release
//   o_reg_addr      current register pointer
//   o_reg_wdata     last received data byte
//   o_reg_we        1-cycle write strobe for o_reg_addr/o_reg_wdata
//   i_reg_rdata     combinational read data for o_reg_addr
//   o_reg_re        1-cycle read strobe, i_reg_rdata latched for transmit
//   o_busy          1 between START and STOP/abort
//   o_start_det     1-cycle pulse on every START / repeated START
module i2c_target_8bit #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h21,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_wdata,
    output logic       o_reg_we,
    input  logic [7:0] i_reg_rdata,
    output logic       o_reg_re,
    output logic       o_busy,
    output logic       o_start_det
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK,
        WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP
    } state_t;

    // Input synchronizers; reset to the idle bus level to avoid false edges.
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_raw;
    logic                   sda_raw;
    logic                   scl_s;
    logic                   sda_s;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i_scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i_sda};
        end
    end

    assign scl_raw = scl_sync[SYNC_STAGES-1];
    assign sda_raw = sda_sync[SYNC_STAGES-1];

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // Level follows the input only once three consecutive samples agree.
    logic [1:0] scl_win;
    logic [1:0] sda_win;
    logic       scl_hold;
    logic       sda_hold;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_win  <= '1;
            sda_win  <= '1;
            scl_hold <= 1'b1;
            sda_hold <= 1'b1;
        end else begin
            scl_win  <= {scl_win[0], scl_raw};
            sda_win  <= {sda_win[0], sda_raw};
            scl_hold <= scl_s;
            sda_hold <= sda_s;
        end
    end

    assign scl_s = (scl_win == {2{scl_raw}}) ? scl_raw : scl_hold;
    assign sda_s = (sda_win == {2{sda_raw}}) ? sda_raw : sda_hold;
`else
    assign scl_s = scl_raw;
    assign sda_s = sda_raw;
`endif

    // History flops for edge and bus-condition detection.
    logic scl_prev;
    logic sda_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    logic scl_rise;
    logic scl_fall;
    logic start_cond;
    logic stop_cond;

    assign scl_rise   =  scl_s & ~scl_prev;
    assign scl_fall   = ~scl_s &  scl_prev;
    assign start_cond =  scl_s &  scl_prev &  sda_prev & ~sda_s;
    assign stop_cond  =  scl_s &  scl_prev & ~sda_prev &  sda_s;

    // Protocol state and registered outputs.
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             rw_q, rw_d;
    logic             oe_q, oe_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             we_q, we_d;
    logic             re_q, re_d;
    logic             busy_q, busy_d;
    logic             start_q, start_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            rw_q    <= 1'b0;
            oe_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            rw_q    <= rw_d;
            oe_q    <= oe_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            re_q    <= re_d;
            busy_q  <= busy_d;
            start_q <= start_d;
        end
    end

    logic [7:0] byte_in;
    logic       last_bit;

    assign byte_in  = {shift_q[6:0], sda_s};
    assign last_bit = (cnt_q == CNT_W'(7));

    // Next-state and output logic; START beats STOP beats any SCL edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        rw_d    = rw_q;
        oe_d    = oe_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        start_d = 1'b0;

        if (start_cond) begin
            state_d = ADDR;
            cnt_d   = '0;
            oe_d    = 1'b0;
            start_d = 1'b1;
        end else if (stop_cond) begin
            state_d = IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
        end else begin
            unique case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (last_bit) begin
                            cnt_d   = '0;
                            rw_d    = sda_s;
                            state_d = (byte_in[7:1] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    // First fall drives ACK, second fall ends the ACK slot.
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else if (rw_q) begin
                            cnt_d   = '0;
                            re_d    = 1'b1;
                            shift_d = i_reg_rdata;
                            oe_d    = ~i_reg_rdata[7];
                            state_d = READ;
                        end else begin
                            cnt_d   = '0;
                            oe_d    = 1'b0;
                            state_d = REG;
                        end
                    end
                end
                REG: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (last_bit) begin
                            cnt_d   = '0;
                            addr_d  = byte_in;
                            state_d = REG_ACK;
                        end
                    end
                end
                WRITE: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (last_bit) begin
                            cnt_d   = '0;
                            wdata_d = byte_in;
                            we_d    = 1'b1;
                            state_d = WRITE_ACK;
                        end
                    end
                end
                REG_ACK, WRITE_ACK: begin
                    // Pointer advances once, in the cycle the write strobe is out.
                    if (state_q == WRITE_ACK && we_q) begin
                        addr_d = addr_q + 8'd1;
                    end
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = WRITE;
                        end
                    end
                end
                READ: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (scl_fall) begin
                        if (cnt_q == CNT_W'(8)) begin
                            cnt_d   = '0;
                            oe_d    = 1'b0;
                            addr_d  = addr_q + 8'd1;
                            state_d = READ_ACK;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            oe_d    = ~shift_q[6];
                        end
                    end
                end
                READ_ACK: begin
                    // cnt_q != 0 marks an ACK seen on the preceding rise.
                    if (scl_rise) begin
                        if (sda_s) begin
                            oe_d    = 1'b0;
                            state_d = WAIT_STOP;
                        end else begin
                            cnt_d = CNT_W'(1);
                        end
                    end else if (scl_fall && cnt_q != '0) begin
                        cnt_d   = '0;
                        re_d    = 1'b1;
                        shift_d = i_reg_rdata;
                        oe_d    = ~i_reg_rdata[7];
                        state_d = READ;
                    end
                end
                default: begin
                    // IDLE and WAIT_STOP only leave on START or STOP.
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    assign o_sda_oe    = oe_q;
    assign o_reg_addr  = addr_q;
    assign o_reg_wdata = wdata_q;
    assign o_reg_we    = we_q;
    assign o_reg_re    = re_q;
    assign o_busy      = busy_q;
    assign o_start_det = start_q;

endmodule

// File: tb/tb_i2c_target_8bit.sv
// Self-checking bench for i2c_target_8bit: an open-drain bus master model,
// a combinational register-file read model and a write/read scoreboard.
module tb_i2c_target_8bit;

    localparam int unsigned Q = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       reg_re;
    logic       busy;
    logic       start_det;

    always #5 clk = ~clk;

    assign sda_line = sda_m & ~sda_oe;

    i2c_target_8bit dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_scl       (scl),
        .i_sda       (sda_line),
        .o_sda_oe    (sda_oe),
        .o_reg_addr  (reg_addr),
        .o_reg_wdata (reg_wdata),
        .o_reg_we    (reg_we),
        .i_reg_rdata (reg_rdata),
        .o_reg_re    (reg_re),
        .o_busy      (busy),
        .o_start_det (start_det)
    );

    function automatic logic [7:0] rmodel(input logic [7:0] a);
        case (a)
            8'h05:   rmodel = 8'hC3;
            8'h06:   rmodel = 8'h3C;
            default: rmodel = a ^ 8'h5A;
        endcase
    endfunction

    assign reg_rdata = rmodel(reg_addr);

    // Monitor: logs strobes and counts events; sole writer of these.
    logic [7:0] wr_log_a [0:31];
    logic [7:0] wr_log_d [0:31];
    logic [7:0] rd_log_a [0:31];
    int         wr_n = 0;
    int         rd_n = 0;
    int         oe_cnt = 0;
    int         start_cnt = 0;

    always @(negedge clk) begin
        if (reg_we && wr_n < 32) begin
            wr_log_a[wr_n] <= reg_addr;
            wr_log_d[wr_n] <= reg_wdata;
            wr_n           <= wr_n + 1;
        end
        if (reg_re && rd_n < 32) begin
            rd_log_a[rd_n] <= reg_addr;
            rd_n           <= rd_n + 1;
        end
        if (sda_oe)    oe_cnt    <= oe_cnt + 1;
        if (start_det) start_cnt <= start_cnt + 1;
    end

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_wr [$];
    logic [7:0] exp_rd [$];
    int         wr_rd = 0;
    int         rd_rd = 0;
    int         total = 0;
    int         bad   = 0;

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(Q);
        scl   = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        scl   = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    tick(Q);
        scl   = 1'b1; tick(2 * Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; tick(Q);
        scl   = 1'b1; tick(Q);
        ack   = sda_line; tick(Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic read_byte(input logic m_ack, output logic [7:0] b);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            tick(Q);
            scl  = 1'b1; tick(Q);
            b[i] = sda_line; tick(Q);
            scl  = 1'b0;
        end
        tick(Q);
        sda_m = m_ack; tick(Q);
        scl   = 1'b1;  tick(2 * Q);
        scl   = 1'b0;  tick(Q);
        sda_m = 1'b1;
    endtask

    // Compare every queued expectation against the monitor log, then extras.
    task automatic check_writes();
        wr_t w;
        while (exp_wr.size() > 0) begin
            w = exp_wr.pop_front();
            if (wr_rd < wr_n) begin
                check("wr_addr", 32'(wr_log_a[wr_rd]), 32'(w.a));
                check("wr_data", 32'(wr_log_d[wr_rd]), 32'(w.d));
            end else begin
                check("wr_missing", 32'(wr_n), 32'(wr_rd + 1));
            end
            wr_rd++;
        end
        check("wr_count", 32'(wr_n), 32'(wr_rd));
    endtask

    task automatic check_reads();
        logic [7:0] a;
        while (exp_rd.size() > 0) begin
            a = exp_rd.pop_front();
            if (rd_rd < rd_n) check("rd_addr", 32'(rd_log_a[rd_rd]), 32'(a));
            else              check("rd_missing", 32'(rd_n), 32'(rd_rd + 1));
            rd_rd++;
        end
        check("rd_count", 32'(rd_n), 32'(rd_rd));
    endtask

    initial begin
        logic       ack;
        logic [7:0] rb;
        int         snap;

        rst = 1'b1; scl = 1'b1; sda_m = 1'b1;
        tick(5);
        check("rst_oe",    32'(sda_oe),    32'(0));
        check("rst_addr",  32'(reg_addr),  32'(0));
        check("rst_wdata", 32'(reg_wdata), 32'(0));
        check("rst_we",    32'(reg_we),    32'(0));
        check("rst_re",    32'(reg_re),    32'(0));
        check("rst_busy",  32'(busy),      32'(0));
        check("rst_start", 32'(start_det), 32'(0));
        rst = 1'b0;
        tick(5);

        // Write burst
        exp_wr.push_back('{a: 8'h10, d: 8'hAA});
        exp_wr.push_back('{a: 8'h11, d: 8'h55});
        bus_start();
        write_byte(8'h42, ack); check("wb_ack_addr", 32'(ack), 32'(0));
        write_byte(8'h10, ack); check("wb_ack_reg",  32'(ack), 32'(0));
        write_byte(8'hAA, ack); check("wb_ack_d0",   32'(ack), 32'(0));
        write_byte(8'h55, ack); check("wb_ack_d1",   32'(ack), 32'(0));
        check("wb_busy_on", 32'(busy), 32'(1));
        bus_stop(); tick(Q);
        check("wb_busy_off", 32'(busy),     32'(0));
        check("wb_ptr",      32'(reg_addr), 32'(8'h12));
        check_writes();

        // Combined read with repeated START
        snap = start_cnt;
        exp_rd.push_back(8'h05);
        exp_rd.push_back(8'h06);
        bus_start();
        write_byte(8'h42, ack); check("cr_ack_w",   32'(ack), 32'(0));
        write_byte(8'h05, ack); check("cr_ack_reg", 32'(ack), 32'(0));
        bus_start();
        write_byte(8'h43, ack); check("cr_ack_r",   32'(ack), 32'(0));
        read_byte(1'b0, rb);    check("cr_byte0",   32'(rb),  32'(8'hC3));
        read_byte(1'b1, rb);    check("cr_byte1",   32'(rb),  32'(8'h3C));
        tick(Q);
        check("cr_oe_after_nack", 32'(sda_oe), 32'(0));
        bus_stop(); tick(Q);
        check("cr_starts", 32'(start_cnt - snap), 32'(2));
        check("cr_busy",   32'(busy),             32'(0));
        check("cr_ptr",    32'(reg_addr),         32'(8'h07));
        check_reads();

        // Address mismatch
        snap = oe_cnt;
        bus_start();
        write_byte(8'h44, ack); check("mm_nack_addr", 32'(ack), 32'(1));
        write_byte(8'h10, ack); check("mm_nack_reg",  32'(ack), 32'(1));
        write_byte(8'hAA, ack); check("mm_nack_data", 32'(ack), 32'(1));
        bus_stop(); tick(Q);
        check("mm_oe_never", 32'(oe_cnt - snap), 32'(0));
        check("mm_busy",     32'(busy),          32'(0));
        check("mm_ptr",      32'(reg_addr),      32'(8'h07));
        check_writes();

        // Pointer wrap-around
        exp_wr.push_back('{a: 8'hFF, d: 8'h11});
        exp_wr.push_back('{a: 8'h00, d: 8'h22});
        bus_start();
        write_byte(8'h42, ack);
        write_byte(8'hFF, ack);
        write_byte(8'h11, ack);
        write_byte(8'h22, ack); check("wr_ack_last", 32'(ack), 32'(0));
        bus_stop(); tick(Q);
        check("wr_ptr", 32'(reg_addr), 32'(8'h01));
        check_writes();

        // STOP after four data bits
        bus_start();
        write_byte(8'h42, ack);
        write_byte(8'h20, ack);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        bus_stop(); tick(Q);
        check("ab_oe",   32'(sda_oe),   32'(0));
        check("ab_busy", 32'(busy),     32'(0));
        check("ab_ptr",  32'(reg_addr), 32'(8'h20));
        check_writes();

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        // SDA pulses with SCL high: short one filtered, long one is a START
        snap = start_cnt;
        sda_m = 1'b0; tick(2);
        sda_m = 1'b1; tick(Q);
        check("gf_short", 32'(start_cnt - snap), 32'(0));
        sda_m = 1'b0; tick(4);
        sda_m = 1'b1; tick(Q);
        check("gf_long", 32'(start_cnt - snap), 32'(1));
        check("gf_busy", 32'(busy),             32'(0));
`endif

        // Reset during the address ACK slot
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(1'(8'h42 >> i));
        check("rs_ack_driven", 32'(sda_oe), 32'(1));
        rst = 1'b1; tick(1);
        check("rs_oe",    32'(sda_oe),    32'(0));
        check("rs_addr",  32'(reg_addr),  32'(0));
        check("rs_wdata", 32'(reg_wdata), 32'(0));
        check("rs_we",    32'(reg_we),    32'(0));
        check("rs_re",    32'(reg_re),    32'(0));
        check("rs_busy",  32'(busy),      32'(0));
        check("rs_start", 32'(start_det), 32'(0));
        rst = 1'b0;
        bus_stop(); tick(Q);
        check("rs_idle", 32'(busy), 32'(0));
        check_writes();
        check_reads();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_target_8bit.md
Name: i2c_target_8bit

Overview:
- Synchronous I2C/SCCB target (slave) responder with an 8-bit register pointer.
- Counterpart to the I2C master request manager and byte generators: it sits on the same open-drain bus and answers START / slave-addr / reg-addr / data / STOP sequences.
- Exposes a simple register-file port. Used as the on-chip bus model for master bring-up and as a configuration target.
- Oversamples SCL/SDA on the system clock; no SCL-domain logic.

Parameters:
- SLAVE_ADDR, 7'h21, 7-bit address this target acknowledges.
- SYNC_STAGES, 2, synchronizer flops on SCL and SDA inputs (legal value >=2).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_scl  in  1  bus SCL (resolved wire level)
- i_sda  in  1  bus SDA (resolved wire level)
- o_sda_oe  out  1  1 = pull SDA low, 0 = release
- o_reg_addr  out  8  current register pointer
- o_reg_wdata  out  8  received data byte
- o_reg_we  out  1  1-cycle write strobe; o_reg_addr/o_reg_wdata valid this cycle
- i_reg_rdata  in  8  read data for o_reg_addr, combinational, sampled on o_reg_re
- o_reg_re  out  1  1-cycle read strobe; byte latched for transmit this cycle
- o_busy  out  1  1 from START to STOP/abort
- o_start_det  out  1  1-cycle pulse on every START or repeated START

Behaviour:
- Reset values: o_sda_oe=0, o_reg_addr=0, o_reg_wdata=0, o_reg_we=0, o_reg_re=0, o_busy=0, o_start_det=0, state=IDLE.
- Inputs pass through SYNC_STAGES flops, plus one history flop for edge detection.
- scl_rise, scl_fall: SCL edges.
- START: SDA falls while SCL is high.
- STOP: SDA rises while SCL is high.
- Latency: START/STOP detected SYNC_STAGES+1 cycles after the bus edge.
- Data bits are sampled on scl_rise, MSB first.
- o_sda_oe changes only on scl_fall, or releases immediately on START/STOP/reset.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
  - START (any state, including mid-byte) -> ADDR; bit counter cleared; o_sda_oe=0; o_start_det pulse.
  - STOP (any state) -> IDLE; o_sda_oe=0. The pointer is retained across transactions.
  - ADDR: after 8 bits, if addr[7:1]==SLAVE_ADDR -> ADDR_ACK; otherwise -> WAIT_STOP (no ACK).
  - ADDR_ACK: o_sda_oe=1 from the scl_fall after bit 8 until the next scl_fall.
    - R/W=0 -> REG.
    - R/W=1 -> on that releasing scl_fall, pulse o_reg_re, latch i_reg_rdata into the shift register, drive bit7 -> READ.
  - REG: 8 bits -> pointer <= byte; REG_ACK (ACK as above) -> WRITE.
  - WRITE: 8 bits -> o_reg_wdata <= byte; o_reg_we pulse on the scl_rise cycle of bit 8 with the current pointer.
    - WRITE_ACK follows: ACK driven, pointer incremented after the strobe cycle.
    - Then -> WRITE.
  - READ: o_sda_oe = ~shift[7] on each scl_fall. After the 8th bit's scl_fall, release -> READ_ACK; pointer increments.
  - READ_ACK: sample master bit on scl_rise.
    - 0 (ACK) -> on the next scl_fall, o_reg_re pulse, load the next byte -> READ.
    - 1 (NACK) -> WAIT_STOP, SDA released.
  - WAIT_STOP: SDA released; leave only on START or STOP.
- Pointer arithmetic is 8-bit modulo: 8'hFF+1 -> 8'h00.
- Read address sequencing:
  - The SCCB/combined read (write reg addr, STOP or repeated START, then read) uses the stored pointer.
  - A read without a reg phase starts at the current pointer.
- START and scl_fall in the same cycle: START wins.
- SCL low forever: the FSM holds. No timeout.
- o_busy=1 in every state except IDLE.

Optional Feature:
- Macro I2C_TARGET_GLITCH_FILTER_EN.
- Defined:
  - After synchronization, each of SCL/SDA passes a 3-sample majority/stability filter. The filtered level updates only when 3 consecutive samples agree.
  - Pulses shorter than 3 i_clk cycles are ignored.
  - Detection latency grows by 2 cycles.
- Undefined: synchronizer output is used directly.

Test Plan:
- Write burst: START, 0x42 (addr 0x21 W), 0x10, 0xAA, 0x55, STOP -> ACK on all four bytes; o_reg_we at addr 0x10 data 0xAA, then addr 0x11 data 0x55; final o_reg_addr=0x12; o_busy 1->0 after STOP.
- Combined read:
  - Sequence: START, 0x42, 0x05, repeated START, 0x43, read 2 bytes (master ACK then NACK), STOP.
  - Bench returns rdata=0xC3 for addr 5 and 0x3C for addr 6.
  - Required: o_reg_re at addr 0x05 then 0x06; SDA carries 0xC3 then 0x3C; o_start_det pulses twice; SDA released after the NACK.
- Address mismatch: START, 0x44, 0x10, 0xAA, STOP -> o_sda_oe never asserted; no o_reg_we; state returns to IDLE.
- Wrap-around: write reg 0xFF, data 0x11, 0x22 -> writes at 0xFF then 0x00; o_reg_addr=0x01.
- Abort and reset:
  - STOP after 4 data bits of a write -> no o_reg_we; IDLE; o_sda_oe=0.
  - i_rst pulsed during ADDR_ACK -> o_sda_oe=0 the next cycle and all outputs at reset values.
- Glitch filter (macro defined):
  - 2-cycle SDA low pulse while SCL high -> no o_start_det.
  - 4-cycle pulse -> o_start_det asserted.
